page_drain: RTL and testbench

- Clk-domain sequencer for the 256-byte page-program write buffer that fills from the SPI side.
- After a page program completes, it reads the buffered bytes out of the buffer's read port and frames them onto the UART tx byte stream.
- It also tells the SPI side when the buffer is in use, and counts pages dropped because a new page arrived while the buffer was still draining.
- It sits between the write buffer's read port and the uart_tx/uart_tx_strobe path.

---
 rtl/page_drain_pkg.sv | 37 +++
 rtl/page_drain_uart_byte_gate.sv | 47 ++++
 rtl/page_drain.sv | 150 +++++++++++++++
 tb/tb_page_drain.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/page_drain_pkg.sv
// Shared constants, drainer state encoding and header-byte helper for the
// page-program drain path between the SPI write buffer and the UART.
package page_drain_pkg;

  localparam int DEPTH   = 256;
  localparam int OFF_W   = $clog2(DEPTH);
  localparam int LEN_W   = OFF_W + 1;
  localparam int HDR_LEN = 5;

  localparam logic [7:0] FRAME_SYNC  = 8'h02;
  // Command that ends a capture and raises page_strobe on the SPI side.
  localparam logic [7:0] SPI_CMD_PP3 = 8'h02;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    RD   = 3'd2,
    WAIT = 3'd3,
    SEND = 3'd4,
    DONE = 3'd5
  } drain_state_e;

  // Header order: sync, addr high/mid/low, length-1 (256 encodes as 8'hFF).
  function automatic logic [7:0] hdr_byte(input logic [2:0]       idx,
                                          input logic [23:0]      addr,
                                          input logic [LEN_W-1:0] len);
    case (idx)
      3'd0:    hdr_byte = FRAME_SYNC;
      3'd1:    hdr_byte = addr[23:16];
      3'd2:    hdr_byte = addr[15:8];
      3'd3:    hdr_byte = addr[7:0];
      3'd4:    hdr_byte = 8'(len - 9'd1);
      default: hdr_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/page_drain_uart_byte_gate.sv
// Ready/strobe gate shared by UART byte producers: strobes only when the UART
// is ready and never in two consecutive cycles.
module uart_byte_gate (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [7:0] data,
  input  logic       uart_tx_ready,
  output logic [7:0] uart_tx,
  output logic       uart_tx_strobe
);

  logic cool_r;
  logic fire_s;

  // Fire when a byte is offered, the UART is ready and the previous cycle was idle.
  always_comb begin
    fire_s = 1'b0;
    if (req && uart_tx_ready && !cool_r) begin
      fire_s = 1'b1;
    end else begin
      fire_s = 1'b0;
    end
  end

  // Byte bus is parked at zero outside a strobe.
  always_comb begin
    uart_tx = 8'h00;
    if (fire_s) begin
      uart_tx = data;
    end else begin
      uart_tx = 8'h00;
    end
  end

  assign uart_tx_strobe = fire_s;

  // Cool-down flag blocks a strobe in the cycle right after one.
  always_ff @(posedge clk) begin
    if (reset) begin
      cool_r <= 1'b0;
    end else begin
      cool_r <= fire_s;
    end
  end

endmodule

// File: rtl/page_drain.sv
// Drains a completed page from the write buffer onto the UART as a framed
// byte stream, owns buf_busy, and counts pages dropped while draining.
module page_drain
  import page_drain_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              page_strobe,
  input  logic [23:0]       page_addr,
  input  logic [LEN_W-1:0]  page_len,
  output logic [OFF_W-1:0]  rd_offset,
  input  logic [7:0]        rd_data,
  output logic [7:0]        uart_tx,
  output logic              uart_tx_strobe,
  input  logic              uart_tx_ready,
  output logic              buf_busy,
  output logic [7:0]        drop_count,
  output logic              overflow
);

  drain_state_e     state_r;
  drain_state_e     state_nxt_s;
  logic [23:0]      addr_r;
  logic [LEN_W-1:0] len_r;
  logic [2:0]       hdr_idx_r;
  logic             lead_r;
  logic [OFF_W-1:0] rd_offset_r;
  logic             busy_r;
  logic [7:0]       drop_r;
  logic             ovf_r;

  logic             req_s;
  logic [7:0]       tx_data_s;
  logic             sent_s;
  logic             start_s;
  logic             drop_s;
  logic             last_hdr_s;
  logic             last_data_s;

  assign start_s     = page_strobe && (state_r == IDLE) && (page_len != 9'd0);
  assign drop_s      = page_strobe && (state_r != IDLE);
  assign last_hdr_s  = (hdr_idx_r == 3'(HDR_LEN - 1));
  assign last_data_s = ({1'b0, rd_offset_r} == (len_r - 9'd1));

  // Next-state and byte-offer logic; lead_r holds off the first header byte
  // one cycle so the frame starts two clocks after page_strobe.
  always_comb begin
    state_nxt_s = state_r;
    req_s       = 1'b0;
    tx_data_s   = 8'h00;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_nxt_s = HDR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HDR: begin
        req_s     = !lead_r;
        tx_data_s = hdr_byte(hdr_idx_r, addr_r, len_r);
        if (sent_s && last_hdr_s) begin
          state_nxt_s = RD;
        end else begin
          state_nxt_s = HDR;
        end
      end
      RD:   state_nxt_s = WAIT;
      WAIT: state_nxt_s = SEND;
      SEND: begin
        req_s     = 1'b1;
        tx_data_s = rd_data;
        if (sent_s && last_data_s) begin
          state_nxt_s = DONE;
        end else if (sent_s) begin
          state_nxt_s = RD;
        end else begin
          state_nxt_s = SEND;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  uart_byte_gate u_gate (
    .clk            (clk),
    .reset          (reset),
    .req            (req_s),
    .data           (tx_data_s),
    .uart_tx_ready  (uart_tx_ready),
    .uart_tx        (uart_tx),
    .uart_tx_strobe (sent_s)
  );

  // State, latched page descriptor and header/data indices.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      addr_r      <= 24'h000000;
      len_r       <= 9'd0;
      hdr_idx_r   <= 3'd0;
      lead_r      <= 1'b0;
      rd_offset_r <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      lead_r  <= start_s;
      if (start_s) begin
        addr_r    <= page_addr;
        len_r     <= page_len;
        hdr_idx_r <= 3'd0;
      end else if ((state_r == HDR) && sent_s) begin
        hdr_idx_r <= hdr_idx_r + 3'd1;
      end
      if ((state_r == HDR) && sent_s && last_hdr_s) begin
        rd_offset_r <= 8'd0;
      end else if ((state_r == SEND) && sent_s && !last_data_s) begin
        rd_offset_r <= rd_offset_r + 8'd1;
      end
    end
  end

  // Buffer ownership and the sticky drop bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= 1'b0;
      drop_r <= 8'd0;
      ovf_r  <= 1'b0;
    end else begin
      if (start_s) begin
        busy_r <= 1'b1;
      end else if (state_r == DONE) begin
        busy_r <= 1'b0;
      end
      if (drop_s) begin
        ovf_r <= 1'b1;
        if (drop_r != 8'hFF) begin
          drop_r <= drop_r + 8'd1;
        end
      end
    end
  end

  assign uart_tx_strobe = sent_s;
  assign rd_offset      = rd_offset_r;
  assign buf_busy       = busy_r;
  assign drop_count     = drop_r;
  assign overflow       = ovf_r;

endmodule

// File: tb/tb_page_drain.sv
// Directed-plus-random bench for page_drain; expected UART frames are built
// from the page descriptor and a buffer model.
module tb_page_drain;

  logic        clk = 1'b0;
  logic        reset;
  logic        page_strobe;
  logic [23:0] page_addr;
  logic [8:0]  page_len;
  logic [7:0]  rd_offset;
  logic [7:0]  rd_data;
  logic [7:0]  uart_tx;
  logic        uart_tx_strobe;
  logic        uart_tx_ready;
  logic        buf_busy;
  logic [7:0]  drop_count;
  logic        overflow;

  page_drain dut (
    .clk            (clk),
    .reset          (reset),
    .page_strobe    (page_strobe),
    .page_addr      (page_addr),
    .page_len       (page_len),
    .rd_offset      (rd_offset),
    .rd_data        (rd_data),
    .uart_tx        (uart_tx),
    .uart_tx_strobe (uart_tx_strobe),
    .uart_tx_ready  (uart_tx_ready),
    .buf_busy       (buf_busy),
    .drop_count     (drop_count),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  // Write-buffer model with a registered read port.
  logic [7:0] mem [256];
  always @(posedge clk) rd_data <= mem[rd_offset];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: capture every strobed byte and note handshake violations.
  logic [7:0] obs_q [$];
  int         cyc_q [$];
  int         viol = 0;
  int         busy_fall_cyc = -1;
  logic       prev_stb = 1'b0;
  logic       prev_busy = 1'b0;
  always @(negedge clk) begin
    if (uart_tx_strobe === 1'b1) begin
      obs_q.push_back(uart_tx);
      cyc_q.push_back(cyc);
      if (uart_tx_ready !== 1'b1) viol <= viol + 1;
      if (prev_stb) viol <= viol + 1;
    end
    if (prev_busy && (buf_busy === 1'b0)) busy_fall_cyc <= cyc;
    prev_stb  <= (uart_tx_strobe === 1'b1);
    prev_busy <= (buf_busy === 1'b1);
  end

  int vectors = 0;
  int miscompares = 0;
  int ready_mode = 0;
  int ps_cyc = 0;
  int base = 0;
  logic [7:0] exp_q [$];
  int lat [8] = '{2, 4, 6, 8, 10, 13, 16, 19};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       uart_tx_ready = 1'b1;
      1:       uart_tx_ready = 1'($urandom_range(0, 1));
      default: uart_tx_ready = 1'b0;
    endcase
  endtask

  task automatic start_page(input logic [23:0] a, input logic [8:0] n);
    page_addr   = a;
    page_len    = n;
    page_strobe = 1'b1;
    ps_cyc      = cyc;
    tick();
    page_strobe = 1'b0;
  endtask

  task automatic pulse_drop();
    page_addr   = 24'($urandom);
    page_len    = 9'($urandom_range(1, 256));
    page_strobe = 1'b1;
    tick();
    page_strobe = 1'b0;
  endtask

  task automatic build_exp(input logic [23:0] a, input logic [8:0] n);
    logic [8:0] m1;
    m1 = n - 9'd1;
    exp_q.delete();
    exp_q.push_back(8'h02);
    exp_q.push_back(a[23:16]);
    exp_q.push_back(a[15:8]);
    exp_q.push_back(a[7:0]);
    exp_q.push_back(m1[7:0]);
    for (int i = 0; i < int'(n); i++) exp_q.push_back(mem[i]);
  endtask

  task automatic wait_frame(input string tag, input int budget);
    int k;
    k = 0;
    while ((buf_busy !== 1'b0) && (k < budget)) begin
      tick();
      k++;
    end
    check({tag, "_timeout"}, 32'(k >= budget), 32'd0);
    for (int j = 0; j < 8; j++) tick();
  endtask

  task automatic cmp_stream(input string tag, input int b);
    check({tag, "_count"}, 32'(obs_q.size() - b), 32'(exp_q.size()));
    for (int i = 0; (i < exp_q.size()) && (b + i < obs_q.size()); i++)
      check($sformatf("%s[%0d]", tag, i), 32'(obs_q[b + i]), 32'(exp_q[i]));
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
  endtask

  initial begin
    logic [23:0] a;
    logic [8:0]  n;
    logic [7:0]  off_hold;
    int          k;
    int          sz;

    reset         = 1'b1;
    page_strobe   = 1'b0;
    page_addr     = 24'h000000;
    page_len      = 9'd0;
    uart_tx_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 3; i++) tick();
    check("rst_rd_offset", 32'(rd_offset), 32'd0);
    check("rst_uart_tx", 32'(uart_tx), 32'd0);
    check("rst_strobe", 32'(uart_tx_strobe), 32'd0);
    check("rst_busy", 32'(buf_busy), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    tick();

    // Basic 3-byte page, ready high: stream, timing and buf_busy window.
    mem[0] = 8'hAA; mem[1] = 8'hBB; mem[2] = 8'hCC;
    base = obs_q.size();
    page_addr = 24'h801000; page_len = 9'd3; page_strobe = 1'b1; ps_cyc = cyc;
    check("t1_busy_before", 32'(buf_busy), 32'd0);
    tick();
    page_strobe = 1'b0;
    check("t1_busy_after", 32'(buf_busy), 32'd1);
    wait_frame("t1", 200);
    build_exp(24'h801000, 9'd3);
    cmp_stream("t1", base);
    for (int i = 0; (i < 8) && (base + i < cyc_q.size()); i++)
      check($sformatf("t1_lat[%0d]", i), 32'(cyc_q[base + i] - ps_cyc), 32'(lat[i]));
    check("t1_busy_fall", 32'(busy_fall_cyc - ps_cyc), 32'd21);
    check("t1_drop", 32'(drop_count), 32'd0);
    check("t1_ovf", 32'(overflow), 32'd0);

    // Full 256-byte page with buffer[i] = i.
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    base = obs_q.size();
    start_page(24'h123456, 9'd256);
    wait_frame("t2", 1200);
    build_exp(24'h123456, 9'd256);
    cmp_stream("t2", base);
    check("t2_rd_offset", 32'(rd_offset), 32'd255);

    // Zero-length page is ignored.
    base = obs_q.size();
    start_page(24'hABCDEF, 9'd0);
    check("t3_busy", 32'(buf_busy), 32'd0);
    for (int i = 0; i < 20; i++) tick();
    check("t3_count", 32'(obs_q.size() - base), 32'd0);
    check("t3_drop", 32'(drop_count), 32'd0);

    // Random page with random ready and one drop mid-drain.
    fill_random();
    a = 24'($urandom); n = 9'($urandom_range(1, 256));
    ready_mode = 1;
    base = obs_q.size();
    start_page(a, n);
    for (int i = 0; i < 3; i++) tick();
    pulse_drop();
    wait_frame("t4", 4000);
    build_exp(a, n);
    cmp_stream("t4", base);
    check("t4_drop", 32'(drop_count), 32'd1);
    check("t4_ovf", 32'(overflow), 32'd1);
    ready_mode = 0;
    tick();

    // page_strobe in the DONE cycle counts as a drop and starts nothing.
    fill_random();
    base = obs_q.size();
    start_page(24'h0000F0, 9'd2);
    k = 0;
    while ((cyc != ps_cyc + 17) && (k < 100)) begin tick(); k++; end
    check("t5_reach_done", 32'(k >= 100), 32'd0);
    pulse_drop();
    wait_frame("t5", 100);
    for (int i = 0; i < 20; i++) tick();
    build_exp(24'h0000F0, 9'd2);
    cmp_stream("t5", base);
    check("t5_drop", 32'(drop_count), 32'd2);
    check("t5_busy", 32'(buf_busy), 32'd0);

    // Ready low for 50 clocks in the middle of the data phase.
    fill_random();
    a = 24'($urandom); n = 9'($urandom_range(10, 60));
    base = obs_q.size();
    start_page(a, n);
    k = 0;
    while ((obs_q.size() < base + 8) && (k < 200)) begin tick(); k++; end
    check("t6_reach_data", 32'(k >= 200), 32'd0);
    ready_mode = 2; uart_tx_ready = 1'b0;
    tick();
    off_hold = rd_offset; sz = obs_q.size();
    for (int i = 0; i < 50; i++) tick();
    check("t6_offset_stable", 32'(rd_offset), 32'(off_hold));
    check("t6_no_strobe", 32'(obs_q.size()), 32'(sz));
    ready_mode = 0;
    wait_frame("t6", 1000);
    build_exp(a, n);
    cmp_stream("t6", base);

    // 300 drops during a long drain saturate drop_count.
    fill_random();
    a = 24'($urandom);
    base = obs_q.size();
    start_page(a, 9'd256);
    for (int i = 0; i < 300; i++) begin tick(); pulse_drop(); end
    wait_frame("t7", 1200);
    build_exp(a, 9'd256);
    cmp_stream("t7", base);
    check("t7_drop_sat", 32'(drop_count), 32'd255);
    check("t7_ovf", 32'(overflow), 32'd1);

    // Reset while SEND is stalled, then a clean frame.
    fill_random();
    base = obs_q.size();
    start_page(24'h55AA33, 9'd20);
    k = 0;
    while ((obs_q.size() < base + 6) && (k < 200)) begin tick(); k++; end
    check("t8_reach_data", 32'(k >= 200), 32'd0);
    ready_mode = 2; uart_tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    check("t8_rd_offset", 32'(rd_offset), 32'd0);
    check("t8_uart_tx", 32'(uart_tx), 32'd0);
    check("t8_strobe", 32'(uart_tx_strobe), 32'd0);
    check("t8_busy", 32'(buf_busy), 32'd0);
    check("t8_drop", 32'(drop_count), 32'd0);
    check("t8_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    ready_mode = 0;
    sz = obs_q.size();
    for (int i = 0; i < 10; i++) tick();
    check("t8_quiet", 32'(obs_q.size()), 32'(sz));
    a = 24'($urandom); n = 9'($urandom_range(1, 40));
    base = obs_q.size();
    start_page(a, n);
    wait_frame("t8", 500);
    build_exp(a, n);
    cmp_stream("t8", base);

    check("handshake_violations", 32'(viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
